prog_load_ctrl: RTL
===================

# prog_load_ctrl

Run-control and memory-write arbiter between an external program loader, the CPU and the shared dual-port memory. It replaces the clock-gate-plus-write-mux arrangement with a registered FSM. The FSM streams host words into memory with a valid/ready handshake and an auto-incrementing address, and holds the CPU in reset while loading. It starts, halts and resumes the CPU through a clock enable on the free-running `clk`. The block sits at top level: host words, and CPU store traffic while running, are routed to the memory write port.

## Interface
- `DATA_W`, 32, memory word width
- `ADDR_W`, 11, memory address width; depth = 2^ADDR_W words
- `BASE_ADR`, 0, first address written in a load session
- `clk`  in  1  single clock for the block, CPU and memory
- `resetn`  in  1  reset, synchronous, active-low
- `host_load`  in  1  pulse: start load session
- `host_run`  in  1  pulse: start/resume CPU
- `host_halt`  in  1  pulse: halt CPU
- `host_wvalid`  in  1  host data beat valid
- `host_wdata`  in  DATA_W  host data word
- `host_wlast`  in  1  final beat of session
- `host_wready`  out  1  beat accepted when `host_wvalid` and `host_wready` are both high
- `cpu_wen` / `cpu_wadrs` / `cpu_wdata`  in  1 / ADDR_W / DATA_W  CPU store request
- `mem_wen` / `mem_wadrs` / `mem_wdata`  out  1 / ADDR_W / DATA_W  memory write port, registered
- `cpu_ce`  out  1  CPU clock enable
- `cpu_resetn`  out  1  CPU reset, active-low
- `state`  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11
- `load_count`  out  ADDR_W+1  words written in the current or last session
- `err`  out  1  sticky session error

## Operation
- **Output decode from the `state` register:**
  - `cpu_ce` = RUN.
  - `cpu_resetn` = RUN or HALT.
  - `host_wready` = LOAD.
- **IDLE:**
  - `host_load` → LOAD; address counter ← BASE_ADR; `load_count` ← 0; `err` ← 0.
  - Otherwise `host_run` with `err`=0 → RUN; `host_run` with `err`=1 is ignored.
- **LOAD:**
  - Accepted beat with `load_count` < 2^ADDR_W: write `host_wdata` at the counter; counter +1, wrapping mod 2^ADDR_W; `load_count` +1.
  - Accepted beat with `load_count` = 2^ADDR_W (overflow): not written; `err` ← 1; → IDLE.
  - Accepted beat with `host_wlast`: write it (unless overflowed), then → IDLE.
  - `host_run` and `host_halt` are ignored.
- **RUN:**
  - `cpu_wen`/`cpu_wadrs`/`cpu_wdata` are forwarded to the memory port.
  - `host_halt` → HALT; `host_load` is ignored (the CPU must be halted first).
- **HALT:**
  - CPU state is frozen (`cpu_ce`=0, `cpu_resetn`=1); CPU writes are blocked.
  - `host_load` → LOAD, which drops `cpu_resetn`; otherwise `host_run` → RUN (resume).
- **Simultaneous pulses:** `host_load` beats `host_run`, which beats `host_halt`. Pulses not legal in the current state are dropped, not queued.
- **Write sources:** the memory port is driven by exactly one source per state. Host in LOAD, CPU in RUN, none otherwise.

## Timing
- Reset values:
  - `state`=IDLE and `err`=0.
  - `load_count`, the address counter, `mem_wen`, `mem_wadrs` and `mem_wdata` = 0.
  - `cpu_ce`=0, `cpu_resetn`=0, `host_wready`=0.
- State transitions happen on the edge that samples the pulse. Decoded outputs change in the following cycle.
- Write latency is 1 cycle: a beat accepted, or a CPU write sampled, at edge N appears on `mem_w*` for the cycle after edge N.
- `mem_wen` is a single-cycle pulse per write. Gaps in `host_wvalid` produce no writes and do not advance the counter.
- Reset mid-LOAD or mid-RUN aborts immediately: `mem_wen`=0 after the reset edge, and any registered pending write is cancelled. Words already written remain in memory.
- A CPU write sampled on the same edge that takes RUN → HALT is still forwarded. No CPU write is forwarded after that.

## Configuration
- `PROG_LOAD_CHECKSUM_EN` defined:
  - Adds input `host_csum` [DATA_W-1:0], sampled on the `host_wlast` beat.
  - The block keeps a running sum, mod 2^DATA_W, of all words written in the session, including the last.
  - On `host_wlast`, a mismatch between the sum and `host_csum` sets `err`.
  - The sum is cleared when `host_load` is accepted.
- Macro not defined: no `host_csum` port and no sum logic; `err` reports overflow only.

## Test plan
- **Reset:** assert `resetn`=0 for 2 cycles → all outputs at their reset values; `state`=00.
- **Load with gaps:** BASE_ADR=0; send 0xA0, 0xA1, 0xA2, 0xA3 with idle cycles between beats; `host_wlast` on the 4th → one `mem_wen` pulse each at addresses 0..3, 1 cycle after acceptance; `load_count`=4; `state`=IDLE.
- **Run and arbitration:**
  - `host_run` → `cpu_ce`=1 and `cpu_resetn`=1 the next cycle.
  - CPU write 0x55 to 0x010 → `mem_wadrs`=0x010, `mem_wdata`=0x55 one cycle later.
  - `host_wvalid`=1 during RUN → `host_wready`=0 and no host write.
- **Halt, resume, reload:**
  - `host_halt` → `cpu_ce`=0 with `cpu_resetn`=1; CPU writes blocked.
  - `host_run` → CPU resumes.
  - `host_halt` then `host_load` in the same cycle as `host_run` → LOAD, `cpu_resetn`=0.
- **Overflow:** ADDR_W=2; 5 beats with `host_wlast` on the 5th → 4 writes at addresses 0..3, `err`=1, IDLE; a following `host_run` is ignored.
- **Checksum (macro on):**
  - Words 1, 2, 3 with `host_csum`=6 → `err`=0.
  - Repeat with `host_csum`=7 → `err`=1 and `host_run` is blocked.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: run-control FSM and memory write arbiter between an external
// program loader, the CPU and the shared memory write port.
//
// IDLE -> LOAD streams host beats into memory at an auto-incrementing address
// while the CPU is held in reset. RUN gates the CPU clock on and forwards CPU
// stores to memory. HALT freezes the CPU (clock off, reset released).
//
// Optional feature macro: PROG_LOAD_CHECKSUM_EN adds the host_csum input and a
// running session sum that is compared on the last beat.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   host_load/run/halt       command pulses (priority load > run > halt)
//   host_wvalid/wdata/wlast  host data beats, host_wready = state is LOAD
//   host_csum                expected session sum (checksum build only)
//   cpu_wen/wadrs/wdata      CPU store request, forwarded only in RUN
//   mem_wen/wadrs/wdata      registered memory write port
//   cpu_ce, cpu_resetn       CPU clock enable / reset decoded from state
//   state                    IDLE=00 LOAD=01 RUN=10 HALT=11
//   load_count               words written in current/last session
//   err                      sticky session error (overflow / checksum)
module prog_load_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int BASE_ADR = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              host_load,
  input  logic              host_run,
  input  logic              host_halt,
  input  logic              host_wvalid,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wlast,
`ifdef PROG_LOAD_CHECKSUM_EN
  input  logic [DATA_W-1:0] host_csum,
`endif
  output logic              host_wready,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_wadrs,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_wadrs,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_ce,
  output logic              cpu_resetn,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // load_count is one bit wider than the address so a full memory is
  // distinguishable from an empty one; a beat arriving at DEPTH is overflow.
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_wadrs_q, mem_wadrs_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                start_load;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_wen_d   = 1'b0;
    mem_wadrs_d = mem_wadrs_q;
    mem_wdata_d = mem_wdata_q;
    start_load  = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (host_load)               start_load = 1'b1;
        else if (host_run && !err_q) state_d    = ST_RUN;
      end
      ST_LOAD: begin
        if (host_wvalid) begin
          if (cnt_q == DEPTH) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            mem_wen_d   = 1'b1;
            mem_wadrs_d = addr_q;
            mem_wdata_d = host_wdata;
            addr_d      = addr_q + ADDR_W'(1);
            cnt_d       = cnt_q + (ADDR_W+1)'(1);
`ifdef PROG_LOAD_CHECKSUM_EN
            sum_d       = sum_q + host_wdata;
`endif
            if (host_wlast) begin
              state_d = ST_IDLE;
`ifdef PROG_LOAD_CHECKSUM_EN
              // Sum includes the last word itself.
              if (sum_q + host_wdata != host_csum) err_d = 1'b1;
`endif
            end
          end
        end
      end
      ST_RUN: begin
        // A store sampled on the halting edge is still forwarded.
        if (cpu_wen) begin
          mem_wen_d   = 1'b1;
          mem_wadrs_d = cpu_wadrs;
          mem_wdata_d = cpu_wdata;
        end
        if (host_halt) state_d = ST_HALT;
      end
      default: begin  // ST_HALT
        if (host_load)     start_load = 1'b1;
        else if (host_run) state_d    = ST_RUN;
      end
    endcase
    if (start_load) begin
      state_d = ST_LOAD;
      addr_d  = BASE;
      cnt_d   = '0;
      err_d   = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wadrs_q <= '0;
      mem_wdata_q <= '0;
`ifdef PROG_LOAD_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_wen_q   <= mem_wen_d;
      mem_wadrs_q <= mem_wadrs_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef PROG_LOAD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign state       = state_q;
  assign cpu_ce      = (state_q == ST_RUN);
  assign cpu_resetn  = (state_q == ST_RUN) || (state_q == ST_HALT);
  assign host_wready = (state_q == ST_LOAD);
  assign mem_wen     = mem_wen_q;
  assign mem_wadrs   = mem_wadrs_q;
  assign mem_wdata   = mem_wdata_q;
  assign load_count  = cnt_q;
  assign err         = err_q;

endmodule
